// File: rtl/chan_pkt_pkg.sv
// Shared types and constants for chan_bin_packetizer.
//   mask_state_t   : mask-load FSM encoding (IDLE=0, LOAD=1, PEND=2)
//   TAG_EN         : 1 when CHAN_PKT_BIN_TAG_EN is defined (bin index appended to tuser)
//   TUSER_*        : m_axis_tuser field offsets for the default widths (BIN_W=11, LEN_W=16);
//                    tuser_len_lsb()/tuser_eob_bit() give the same offsets for any width
//   mask_words()   : number of MASK_W-bit words that cover 2**BIN_W bins
// Optional feature macro: CHAN_PKT_BIN_TAG_EN
package chan_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } mask_state_t;

`ifdef CHAN_PKT_BIN_TAG_EN
    localparam int TAG_EN = 1;
`else
    localparam int TAG_EN = 0;
`endif

    localparam int DEF_BIN_W     = 11;
    localparam int DEF_LEN_W     = 16;
    localparam int TUSER_BIN_LSB = 0;
    localparam int TUSER_LEN_LSB = TAG_EN * DEF_BIN_W;
    localparam int TUSER_EOB_BIT = TUSER_LEN_LSB + DEF_LEN_W;

    function automatic int tuser_len_lsb(input int bin_w);
        return TAG_EN * bin_w;
    endfunction

    function automatic int tuser_eob_bit(input int bin_w, input int len_w);
        return tuser_len_lsb(bin_w) + len_w;
    endfunction

    function automatic int mask_words(input int bin_w, input int mask_w);
        return (1 << bin_w) / mask_w;
    endfunction

endpackage

// File: rtl/chan_mask_ram.sv
// Double-banked bin mask store.
//   clk, rst_n          : clock, async active-low reset (bank select only)
//   wr_en/wr_addr/wr_data : MASK_W-wide word write into the shadow bank
//   rd_en/rd_addr/rd_bit  : registered 1-bit read of the active bank
//   swap                : toggle active/shadow; the read in the same cycle
//                         already sees the newly activated bank
// Mask contents are not reset.
module chan_mask_ram #(
    parameter int BIN_W  = 11,
    parameter int MASK_W = 32
) (
    input  logic                                ce_clk,
    input  logic                                ce_rst_n,
    input  logic                                wr_en,
    input  logic [BIN_W-$clog2(MASK_W)-1:0]     wr_addr,
    input  logic [MASK_W-1:0]                   wr_data,
    input  logic                                rd_en,
    input  logic [BIN_W-1:0]                    rd_addr,
    output logic                                rd_bit,
    input  logic                                swap
);

    localparam int NBITS  = 2 ** BIN_W;
    localparam int LOG_MW = $clog2(MASK_W);

    logic [NBITS-1:0] mem [2];
    logic             bank;
    logic [BIN_W-1:0] wr_base;

    assign wr_base = {wr_addr, {LOG_MW{1'b0}}};

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            bank <= 1'b0;
        end else if (swap) begin
            bank <= !bank;
        end
    end

    always_ff @(posedge ce_clk) begin
        if (wr_en) begin
            mem[!bank][wr_base +: MASK_W] <= wr_data;
        end
        if (rd_en) begin
            rd_bit <= mem[bank ^ swap][rd_addr];
        end
    end

endmodule

// File: rtl/chan_bin_packetizer.sv
// Bin mask filter and packetiser between channelizer core and AXI wrapper.
//   ce_clk, ce_rst_n        : clock, async active-low reset
//   cfg_fft_size            : bins per frame (power of 2, 8..2**BIN_W)
//   cfg_payload_len         : words per packet (0 treated as 1)
//   cfg_eob_req             : pulse, close stream at next frame end
//   s_axis_mask_*           : mask reload stream, tlast commits
//   s_axis_*                : samples, tuser = bin index, tlast = frame end
//   m_axis_*                : packets, tuser = {eob, length} on tlast beat
//   frame_err_cnt           : saturating count of misaligned frames
//   mask_loaded             : a mask has been committed (else pass-all)
// Optional feature macro: CHAN_PKT_BIN_TAG_EN appends the bin index to
// m_axis_tuser (low BIN_W bits) on every beat.
module chan_bin_packetizer
    import chan_pkt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BIN_W  = 11,
    parameter int LEN_W  = 16,
    parameter int MASK_W = 32
) (
    input  logic                          ce_clk,
    input  logic                          ce_rst_n,
    input  logic [BIN_W:0]                cfg_fft_size,
    input  logic [LEN_W-1:0]              cfg_payload_len,
    input  logic                          cfg_eob_req,
    input  logic [MASK_W-1:0]             s_axis_mask_tdata,
    input  logic                          s_axis_mask_tlast,
    input  logic                          s_axis_mask_tvalid,
    output logic                          s_axis_mask_tready,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic [BIN_W-1:0]              s_axis_tuser,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [LEN_W+TAG_EN*BIN_W:0]   m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [15:0]                   frame_err_cnt,
    output logic                          mask_loaded
);

    localparam int AW      = BIN_W - $clog2(MASK_W);
    localparam int NWORDS  = mask_words(BIN_W, MASK_W);
    localparam int LEN_LSB = tuser_len_lsb(BIN_W);
    localparam int EOB_BIT = tuser_eob_bit(BIN_W, LEN_W);
    localparam logic [AW:0] WA_END = (AW+1)'(NWORDS);

    mask_state_t state, state_nx;
    logic [AW:0] waddr;
    logic        mask_beat, wr_en, swap_now, keep_bit;

    logic        accept, s2_stall, s1_adv, s2_load;
    logic        s1_valid, s1_last, s1_pass;
    logic [DATA_W-1:0] s1_data;
    logic        s2_valid, s2_last, s2_eob;
    logic [DATA_W-1:0] s2_data;
    logic [LEN_W-1:0]  s2_len;
`ifdef CHAN_PKT_BIN_TAG_EN
    logic [BIN_W-1:0]  s1_bin, s2_bin;
`endif

    logic [BIN_W-1:0] exp_bin;
    logic [BIN_W:0]   fft_m1;
    logic             frame_bad, bin_mis;

    logic [LEN_W-1:0] pkt_cnt, cur_len, len_cfg, len_now;
    logic             eob_pend, eob_hit, pkt_end;

    // ---------------- handshakes ----------------
    assign s2_stall      = s2_valid && !m_axis_tready;
    assign s_axis_tready = !s2_stall && !(s1_valid && s2_stall);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign s1_adv        = s1_valid && !s2_stall;
    assign s2_load       = s1_adv && (s1_pass || keep_bit);

    // ---------------- mask FSM ----------------
    assign swap_now  = (state == PEND) && accept && (s_axis_tuser == '0);
    assign mask_beat = s_axis_mask_tvalid && s_axis_mask_tready;
    assign wr_en     = mask_beat && (waddr < WA_END);

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx           = state;
        s_axis_mask_tready = 1'b1;
        case (state)
            IDLE: if (s_axis_mask_tvalid) state_nx = s_axis_mask_tlast ? PEND : LOAD;
            LOAD: if (s_axis_mask_tvalid && s_axis_mask_tlast) state_nx = PEND;
            PEND: begin
                s_axis_mask_tready = 1'b0;
                if (swap_now) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Write address saturates one past the last word so overflow words drop.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            waddr       <= '0;
            mask_loaded <= 1'b0;
        end else begin
            if (mask_beat) begin
                if (s_axis_mask_tlast)     waddr <= '0;
                else if (waddr != WA_END)  waddr <= waddr + 1'b1;
            end
            if (swap_now) mask_loaded <= 1'b1;
        end
    end

    chan_mask_ram #(
        .BIN_W  (BIN_W),
        .MASK_W (MASK_W)
    ) u_mask_ram (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .wr_en    (wr_en),
        .wr_addr  (waddr[AW-1:0]),
        .wr_data  (s_axis_mask_tdata),
        .rd_en    (accept),
        .rd_addr  (s_axis_tuser),
        .rd_bit   (keep_bit),
        .swap     (swap_now)
    );

    // ---------------- bin checker ----------------
    // One error per frame: later mismatches in an already-bad frame are
    // not counted again; the flag clears on the frame's tlast.
    assign fft_m1  = cfg_fft_size - 1'b1;
    assign bin_mis = (s_axis_tuser != exp_bin) || (s_axis_tlast && ({1'b0, exp_bin} != fft_m1));

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            exp_bin       <= '0;
            frame_bad     <= 1'b0;
            frame_err_cnt <= '0;
        end else if (accept) begin
            exp_bin   <= s_axis_tlast ? '0 : exp_bin + 1'b1;
            frame_bad <= s_axis_tlast ? 1'b0 : (frame_bad || bin_mis);
            if (bin_mis && !frame_bad && (frame_err_cnt != 16'hFFFF))
                frame_err_cnt <= frame_err_cnt + 1'b1;
        end
    end

    // ---------------- packet counter ----------------
    // Packet length is latched at the first word of each packet so config
    // changes only land on packet boundaries. EOB attaches to the kept
    // frame-tlast beat; if that beat is masked out the request stays pending.
    assign len_cfg = (cfg_payload_len == '0) ? LEN_W'(1) : cfg_payload_len;
    assign len_now = (pkt_cnt == '0) ? len_cfg : cur_len;
    assign eob_hit = eob_pend && s1_last;
    assign pkt_end = (pkt_cnt == len_now - 1'b1) || eob_hit;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            pkt_cnt  <= '0;
            cur_len  <= '0;
            eob_pend <= 1'b0;
        end else begin
            if (s2_load) begin
                cur_len <= len_now;
                pkt_cnt <= pkt_end ? '0 : pkt_cnt + 1'b1;
            end
            eob_pend <= (eob_pend && !(s2_load && eob_hit)) || cfg_eob_req;
        end
    end

    // ---------------- pipeline ----------------
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pass  <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_eob   <= 1'b0;
            s2_len   <= '0;
            s2_data  <= '0;
`ifdef CHAN_PKT_BIN_TAG_EN
            s1_bin   <= '0;
            s2_bin   <= '0;
`endif
        end else if (!s2_stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= s_axis_tdata;
                s1_last <= s_axis_tlast;
                s1_pass <= !(mask_loaded || swap_now);
`ifdef CHAN_PKT_BIN_TAG_EN
                s1_bin  <= s_axis_tuser;
`endif
            end
            s2_valid <= s2_load;
            if (s2_load) begin
                s2_data <= s1_data;
                s2_last <= pkt_end;
                s2_eob  <= eob_hit;
                s2_len  <= pkt_end ? pkt_cnt + 1'b1 : '0;
`ifdef CHAN_PKT_BIN_TAG_EN
                s2_bin  <= s1_bin;
`endif
            end
        end
    end

    assign m_axis_tvalid = s2_valid;
    assign m_axis_tdata  = s2_data;
    assign m_axis_tlast  = s2_last;

    always_comb begin
        m_axis_tuser                   = '0;
        m_axis_tuser[EOB_BIT]          = s2_eob;
        m_axis_tuser[LEN_LSB +: LEN_W] = s2_len;
`ifdef CHAN_PKT_BIN_TAG_EN
        m_axis_tuser[TUSER_BIN_LSB +: BIN_W] = s2_bin;
`endif
    end

endmodule
